// File: rtl/pc_fetch_ctrl.sv
// Instruction-fetch front end: owns the PC, drives fetch address/enable, flags new fetches
// and redirect flushes, and parks a branch target while the pipeline is stalled.
module pc_fetch_ctrl #(
  parameter int              ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int              PC_STEP  = 1,
  parameter int              COUNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         stall,
  input  logic               mem_busy_i,
  input  logic               branch_flag_i,
  input  logic [ADDR_W-1:0]  branch_target_i,
  output logic [ADDR_W-1:0]  pc_o,
  output logic               ce_o,
  output logic               fetch_valid_o,
  output logic               redirect_o,
  output logic               pend_o,
  output logic [COUNT_W-1:0] fetch_count_o
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

  typedef enum logic [1:0] {IDLE, RUN, HOLD, PEND} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   tgt_q, tgt_d;
  logic                ce_q, ce_d;
  logic                valid_q, valid_d;
  logic                redirect_q, redirect_d;
  logic                pend_q, pend_d;
  logic [COUNT_W-1:0]  count_q, count_d;
  logic                stop;
  logic                unused_stall;

  assign stop         = stall[0];
  assign unused_stall = ^stall[5:1];

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    tgt_d      = tgt_q;
    ce_d       = 1'b1;
    valid_d    = 1'b0;
    redirect_d = 1'b0;
    pend_d     = pend_q;
    case (state_q)
      IDLE: begin
        state_d = RUN;
        valid_d = 1'b1;
      end
      RUN, HOLD: begin
        if (branch_flag_i && !stop) begin
          pc_d       = branch_target_i;
          redirect_d = 1'b1;
          valid_d    = !mem_busy_i;
          state_d    = mem_busy_i ? HOLD : RUN;
        end else if (branch_flag_i) begin
          tgt_d   = branch_target_i;
          pend_d  = 1'b1;
          state_d = PEND;
        end else if (stop || mem_busy_i) begin
          state_d = HOLD;
        end else begin
          // Leaving HOLD re-fetches the held PC instead of skipping it.
          if (state_q == RUN) pc_d = pc_q + STEP;
          valid_d = 1'b1;
          state_d = RUN;
        end
      end
      PEND: begin
        if (!stop) begin
          pc_d       = branch_flag_i ? branch_target_i : tgt_q;
          redirect_d = 1'b1;
          pend_d     = 1'b0;
          valid_d    = !mem_busy_i;
          state_d    = mem_busy_i ? HOLD : RUN;
        end else if (branch_flag_i) begin
          tgt_d = branch_target_i;
        end
      end
      default: state_d = IDLE;
    endcase
    count_d = (valid_d && (count_q != '1)) ? count_q + COUNT_W'(1) : count_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      tgt_q      <= '0;
      ce_q       <= 1'b0;
      valid_q    <= 1'b0;
      redirect_q <= 1'b0;
      pend_q     <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      tgt_q      <= tgt_d;
      ce_q       <= ce_d;
      valid_q    <= valid_d;
      redirect_q <= redirect_d;
      pend_q     <= pend_d;
      count_q    <= count_d;
    end
  end

  assign pc_o          = pc_q;
  assign ce_o          = ce_q;
  assign fetch_valid_o = valid_q;
  assign redirect_o    = redirect_q;
  assign pend_o        = pend_q;
  assign fetch_count_o = count_q;

endmodule
